// File: rtl/rv64g_l2_mshr_file.sv
// rtl/rv64g_l2_mshr_file.sv - L2 miss status holding register file with line-conflict blocking
module rv64g_l2_mshr_file #(
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int TYPE_W   = 3,
    parameter int CORES    = 4,
    parameter int ENTRIES  = 4,
    parameter int LINE_OFF = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [ADDR_W-1:0]             alloc_addr_i,
    input  logic [SOURCE_W-1:0]           alloc_source_i,
    input  logic [TYPE_W-1:0]             alloc_type_i,
    output logic [$clog2(ENTRIES)-1:0]    alloc_idx_o,
    output logic                          alloc_conflict_o,
    input  logic                          dealloc_i,
    input  logic [$clog2(ENTRIES)-1:0]    dealloc_idx_i,
    input  logic                          set_probes_i,
    input  logic [$clog2(ENTRIES)-1:0]    set_probes_idx_i,
    input  logic [CORES-1:0]              probes_mask_i,
    input  logic                          probe_ack_i,
    input  logic [$clog2(ENTRIES)-1:0]    probe_ack_idx_i,
    input  logic [$clog2(CORES)-1:0]      probe_ack_core_i,
    output logic [ENTRIES-1:0]            valid_o,
    output logic [ENTRIES-1:0]            probes_done_o,
    output logic [ENTRIES*ADDR_W-1:0]     entry_addr_o,
    output logic [ENTRIES*SOURCE_W-1:0]   entry_source_o,
    output logic [ENTRIES*TYPE_W-1:0]     entry_type_o,
    output logic [ENTRIES*CORES-1:0]      pending_probes_o,
    output logic [$clog2(ENTRIES+1)-1:0]  count_o,
    output logic                          full_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES+1);

    logic [ENTRIES-1:0]  valid_q, valid_d, probes_set_q, probes_set_d;
    logic [ADDR_W-1:0]   addr_q   [ENTRIES];
    logic [SOURCE_W-1:0] source_q [ENTRIES];
    logic [TYPE_W-1:0]   type_q   [ENTRIES];
    logic [CORES-1:0]    mask_q   [ENTRIES];
    logic [CORES-1:0]    mask_d   [ENTRIES];
    logic                conflict;
    logic [IDX_W-1:0]    free_idx;
    logic                alloc_fire;
    logic [CORES-1:0]    ack_keep;
    logic [CNT_W-1:0]    count;
    logic                unused_line_offset;

    // Offset bits within a line never take part in conflict detection.
    assign unused_line_offset = ^alloc_addr_i[LINE_OFF-1:0];

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && addr_q[i][ADDR_W-1:LINE_OFF] == alloc_addr_i[ADDR_W-1:LINE_OFF])
                conflict = 1'b1;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i])
                free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < ENTRIES; i++)
            count = count + CNT_W'(valid_q[i]);
    end

    assign full_o           = &valid_q;
    assign alloc_conflict_o = conflict;
    assign alloc_ready_o    = alloc_valid_i & ~full_o & ~conflict;
    assign alloc_fire       = alloc_ready_o;
    assign alloc_idx_o      = free_idx;
    assign count_o          = count;
    assign valid_o          = valid_q;
    assign ack_keep         = ~(CORES'(1) << probe_ack_core_i);

    // Within a live entry: set_probes loads first, an ack then masks, and dealloc overrides both.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]      = valid_q[i];
            probes_set_d[i] = probes_set_q[i];
            mask_d[i]       = mask_q[i];
            if (valid_q[i]) begin
                if (set_probes_i && set_probes_idx_i == IDX_W'(i)) begin
                    mask_d[i]       = probes_mask_i;
                    probes_set_d[i] = 1'b1;
                end
                if (probe_ack_i && probe_ack_idx_i == IDX_W'(i))
                    mask_d[i] = mask_d[i] & ack_keep;
                if (dealloc_i && dealloc_idx_i == IDX_W'(i)) begin
                    valid_d[i]      = 1'b0;
                    probes_set_d[i] = 1'b0;
                    mask_d[i]       = '0;
                end
            end else if (alloc_fire && free_idx == IDX_W'(i)) begin
                valid_d[i]      = 1'b1;
                probes_set_d[i] = 1'b0;
                mask_d[i]       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            probes_set_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                addr_q[i]   <= '0;
                source_q[i] <= '0;
                type_q[i]   <= '0;
                mask_q[i]   <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            probes_set_q <= probes_set_d;
            for (int i = 0; i < ENTRIES; i++) begin
                mask_q[i] <= mask_d[i];
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    addr_q[i]   <= alloc_addr_i;
                    source_q[i] <= alloc_source_i;
                    type_q[i]   <= alloc_type_i;
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_out
        assign entry_addr_o[g*ADDR_W +: ADDR_W]       = addr_q[g];
        assign entry_source_o[g*SOURCE_W +: SOURCE_W] = source_q[g];
        assign entry_type_o[g*TYPE_W +: TYPE_W]       = type_q[g];
        assign pending_probes_o[g*CORES +: CORES]     = mask_q[g];
        assign probes_done_o[g] = valid_q[g] & probes_set_q[g] & ~|mask_q[g];
    end
endmodule

// File: tb/tb_rv64g_l2_mshr_file.sv
// tb/tb_rv64g_l2_mshr_file.sv - directed and randomized bench for the L2 MSHR file
module tb_rv64g_l2_mshr_file;
    localparam int E = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_valid_i, alloc_ready_o, alloc_conflict_o;
    logic [63:0]  alloc_addr_i;
    logic [5:0]   alloc_source_i;
    logic [2:0]   alloc_type_i;
    logic [1:0]   alloc_idx_o;
    logic         dealloc_i, set_probes_i, probe_ack_i;
    logic [1:0]   dealloc_idx_i, set_probes_idx_i, probe_ack_idx_i, probe_ack_core_i;
    logic [3:0]   probes_mask_i;
    logic [3:0]   valid_o, probes_done_o;
    logic [255:0] entry_addr_o;
    logic [23:0]  entry_source_o;
    logic [11:0]  entry_type_o;
    logic [15:0]  pending_probes_o;
    logic [2:0]   count_o;
    logic         full_o;

    always #5 clk = ~clk;

    rv64g_l2_mshr_file #(.ADDR_W(64), .SOURCE_W(6), .TYPE_W(3), .CORES(4), .ENTRIES(4), .LINE_OFF(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_addr_i(alloc_addr_i),
        .alloc_source_i(alloc_source_i), .alloc_type_i(alloc_type_i), .alloc_idx_o(alloc_idx_o),
        .alloc_conflict_o(alloc_conflict_o), .dealloc_i(dealloc_i), .dealloc_idx_i(dealloc_idx_i),
        .set_probes_i(set_probes_i), .set_probes_idx_i(set_probes_idx_i), .probes_mask_i(probes_mask_i),
        .probe_ack_i(probe_ack_i), .probe_ack_idx_i(probe_ack_idx_i), .probe_ack_core_i(probe_ack_core_i),
        .valid_o(valid_o), .probes_done_o(probes_done_o), .entry_addr_o(entry_addr_o),
        .entry_source_o(entry_source_o), .entry_type_o(entry_type_o),
        .pending_probes_o(pending_probes_o), .count_o(count_o), .full_o(full_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: one record per entry, updated by the operation rules.
    bit          m_valid [E];
    bit          m_ps    [E];
    logic [63:0] m_addr  [E];
    logic [5:0]  m_src   [E];
    logic [2:0]  m_type  [E];
    logic [3:0]  m_mask  [E];

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < E; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit m_conflict(logic [63:0] a);
        for (int i = 0; i < E; i++)
            if (m_valid[i] && (m_addr[i] >> 6) == (a >> 6)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < E; i++) begin
            m_valid[i] = 0; m_ps[i] = 0; m_addr[i] = '0;
            m_src[i] = '0; m_type[i] = '0; m_mask[i] = '0;
        end
    endtask

    task automatic compare_all();
        int f, cnt;
        bit conf;
        logic [255:0] ea;
        logic [23:0] es;
        logic [11:0] et;
        logic [15:0] ep;
        logic [3:0] ev, ed;
        f = m_free();
        conf = m_conflict(alloc_addr_i);
        cnt = 0;
        for (int i = 0; i < E; i++) begin
            ev[i] = m_valid[i];
            ed[i] = m_valid[i] && m_ps[i] && m_mask[i] == 4'b0;
            ea[i*64 +: 64] = m_addr[i];
            es[i*6 +: 6] = m_src[i];
            et[i*3 +: 3] = m_type[i];
            ep[i*4 +: 4] = m_mask[i];
            cnt += int'(m_valid[i]);
        end
        check("alloc_ready", alloc_ready_o, alloc_valid_i && f >= 0 && !conf);
        check("alloc_idx", alloc_idx_o, (f < 0) ? 0 : f);
        check("alloc_conflict", alloc_conflict_o, conf);
        check("valid", valid_o, ev);
        check("probes_done", probes_done_o, ed);
        check("entry_addr", entry_addr_o, ea);
        check("entry_source", entry_source_o, es);
        check("entry_type", entry_type_o, et);
        check("pending", pending_probes_o, ep);
        check("count", count_o, cnt);
        check("full", full_o, f < 0);
    endtask

    task automatic model_step();
        bit ov [E];
        int f;
        bit fire;
        f = m_free();
        fire = alloc_valid_i && f >= 0 && !m_conflict(alloc_addr_i);
        ov = m_valid;
        if (set_probes_i && ov[set_probes_idx_i]) begin
            m_mask[set_probes_idx_i] = probes_mask_i;
            m_ps[set_probes_idx_i] = 1;
        end
        if (probe_ack_i && ov[probe_ack_idx_i])
            m_mask[probe_ack_idx_i][probe_ack_core_i] = 1'b0;
        if (dealloc_i && ov[dealloc_idx_i]) begin
            m_valid[dealloc_idx_i] = 0;
            m_ps[dealloc_idx_i] = 0;
            m_mask[dealloc_idx_i] = '0;
        end
        if (fire) begin
            m_valid[f] = 1; m_ps[f] = 0; m_mask[f] = '0;
            m_addr[f] = alloc_addr_i; m_src[f] = alloc_source_i; m_type[f] = alloc_type_i;
        end
    endtask

    task automatic clear_in();
        alloc_valid_i = 0; alloc_addr_i = '0; alloc_source_i = '0; alloc_type_i = '0;
        dealloc_i = 0; dealloc_idx_i = '0; set_probes_i = 0; set_probes_idx_i = '0;
        probes_mask_i = '0; probe_ack_i = 0; probe_ack_idx_i = '0; probe_ack_core_i = '0;
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic alloc(logic [63:0] a, logic [5:0] s, logic [2:0] t);
        clear_in();
        alloc_valid_i = 1; alloc_addr_i = a; alloc_source_i = s; alloc_type_i = t;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_in();
        model_reset();
        @(negedge clk);
        alloc_valid_i = 1;
        #1 compare_all();
        alloc_valid_i = 0;
        @(negedge clk);
        rst_n = 1;

        alloc(64'h1000, 6'd5, 3'd4);
        #1 check("first_idx", alloc_idx_o, 0);
        step();
        check("first_valid", valid_o, 4'b0001);
        check("first_addr", entry_addr_o[63:0], 64'h1000);
        check("first_src", entry_source_o[5:0], 6'd5);
        check("first_count", count_o, 1);

        alloc(64'h1020, 6'd1, 3'd1);
        #1 check("same_line_conflict", alloc_conflict_o, 1);
        check("same_line_ready", alloc_ready_o, 0);
        step();
        alloc(64'h1040, 6'd2, 3'd2);
        #1 check("next_line_idx", alloc_idx_o, 1);
        check("next_line_ready", alloc_ready_o, 1);
        step();
        alloc(64'h2000, 6'd3, 3'd3); step();
        alloc(64'h3000, 6'd4, 3'd5); step();
        check("full_after_fill", full_o, 1);

        alloc(64'h4000, 6'd7, 3'd6);
        dealloc_i = 1; dealloc_idx_i = 2;
        #1 check("dealloc_cycle_ready", alloc_ready_o, 0);
        step();
        dealloc_i = 0;
        #1 check("after_dealloc_ready", alloc_ready_o, 1);
        check("after_dealloc_idx", alloc_idx_o, 2);
        step();

        clear_in(); set_probes_i = 1; set_probes_idx_i = 1; probes_mask_i = 4'b1011; step();
        check("probe_load", pending_probes_o[7:4], 4'b1011);
        check("probe_load_done", probes_done_o[1], 0);
        clear_in(); probe_ack_i = 1; probe_ack_idx_i = 1; probe_ack_core_i = 0; step();
        check("ack_core0", pending_probes_o[7:4], 4'b1010);
        probe_ack_core_i = 3; step();
        check("ack_core3", pending_probes_o[7:4], 4'b0010);
        probe_ack_core_i = 1; step();
        check("ack_core1", pending_probes_o[7:4], 4'b0000);
        check("ack_done", probes_done_o[1], 1);

        clear_in(); set_probes_i = 1; set_probes_idx_i = 0; probes_mask_i = 4'b1111;
        probe_ack_i = 1; probe_ack_idx_i = 0; probe_ack_core_i = 2; step();
        check("set_and_ack", pending_probes_o[3:0], 4'b1011);
        clear_in(); dealloc_i = 1; dealloc_idx_i = 3; step();
        clear_in(); probe_ack_i = 1; probe_ack_idx_i = 3; probe_ack_core_i = 0; step();
        check("ack_dead_valid", valid_o, 4'b0111);
        clear_in(); set_probes_i = 1; set_probes_idx_i = 2; probes_mask_i = 4'b0110; step();
        set_probes_idx_i = 1; probes_mask_i = 4'b0100; step();
        clear_in();

        #3 rst_n = 0;
        #1 check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_pending", pending_probes_o, 0);
        check("rst_addr", entry_addr_o, 0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1;
        alloc(64'h5000, 6'd9, 3'd1);
        #1 check("post_rst_idx", alloc_idx_o, 0);
        step();

        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            clear_in();
            alloc_valid_i = ($urandom_range(0, 1) == 1);
            alloc_addr_i = (64'($urandom_range(0, 9)) << 6) | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) alloc_addr_i[63] = 1'b1;
            alloc_source_i = 6'($urandom_range(0, 63));
            alloc_type_i = 3'($urandom_range(0, 7));
            dealloc_i = ($urandom_range(0, 2) == 0);
            dealloc_idx_i = 2'($urandom_range(0, 3));
            set_probes_i = ($urandom_range(0, 3) == 0);
            set_probes_idx_i = 2'($urandom_range(0, 3));
            probes_mask_i = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            probe_ack_i = ($urandom_range(0, 1) == 1);
            probe_ack_idx_i = 2'($urandom_range(0, 3));
            probe_ack_core_i = 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv64g_l2_mshr_file.md
Name: rv64g_l2_mshr_file

Overview:
- Multi-entry miss status holding register file for the L2 controller.
- Tracks up to ENTRIES outstanding transactions, each with its own address, source, opcode and per-core pending-probe mask.
- Blocks allocation of a second transaction to a cache line that already has a live entry, so accesses to the same line are serialised.
- Sits between the L2 request arbiter (allocation) and the coherence FSMs (probe bookkeeping, retirement).

Parameters:
- ADDR_W, 64, physical address width.
- SOURCE_W, 6, TileLink source width (L1 source + client ID).
- TYPE_W, 3, opcode width.
- CORES, 4, number of probeable clients (≥2).
- ENTRIES, 4, number of MSHR entries (≥2).
- LINE_OFF, 6, log2 of line size in bytes; the low LINE_OFF address bits are ignored for conflict checks.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  allocation request
- alloc_ready_o  out  1  allocation accepted this cycle if valid
- alloc_addr_i  in  ADDR_W  request address
- alloc_source_i  in  SOURCE_W  request source
- alloc_type_i  in  TYPE_W  request opcode
- alloc_idx_o  out  $clog2(ENTRIES)  entry index chosen, valid when alloc_ready_o
- alloc_conflict_o  out  1  a live entry holds the same line as alloc_addr_i
- dealloc_i  in  1  retire an entry
- dealloc_idx_i  in  $clog2(ENTRIES)  entry to retire
- set_probes_i  in  1  load a probe mask
- set_probes_idx_i  in  $clog2(ENTRIES)  target entry
- probes_mask_i  in  CORES  cores probed
- probe_ack_i  in  1  probe ack received
- probe_ack_idx_i  in  $clog2(ENTRIES)  target entry
- probe_ack_core_i  in  $clog2(CORES)  acking core
- valid_o  out  ENTRIES  per-entry live bit
- probes_done_o  out  ENTRIES  per-entry: live, probes set, pending mask zero
- entry_addr_o  out  ENTRIES*ADDR_W  flattened addresses; entry i occupies bits [i*ADDR_W +: ADDR_W]
- entry_source_o  out  ENTRIES*SOURCE_W  flattened sources, same packing
- entry_type_o  out  ENTRIES*TYPE_W  flattened opcodes, same packing
- pending_probes_o  out  ENTRIES*CORES  flattened pending masks, same packing
- count_o  out  $clog2(ENTRIES+1)  number of live entries
- full_o  out  1  all entries live

Behaviour:
- Reset (asynchronous) clears every register. All outputs are 0, except alloc_ready_o, which equals alloc_valid_i and no conflict.
- Per-entry state: valid, addr, source, type, pending mask, probes_set flag.
- Conflict: alloc_conflict_o = OR over live entries of (addr[ADDR_W-1:LINE_OFF] == alloc_addr_i[ADDR_W-1:LINE_OFF]). Purely combinational on current state.
- alloc_ready_o = alloc_valid_i & !full_o & !alloc_conflict_o, computed combinationally.
- alloc_idx_o = lowest-index non-live entry (priority encoder). It is 0 when full.
- On alloc_valid_i & alloc_ready_o, at the next clk edge the chosen entry becomes live, captures addr/source/type, and clears its mask and probes_set. Latency 1 cycle.
- Allocation depends only on current-cycle state. An entry being deallocated in the same cycle is neither reusable nor considered freed for conflict checks until the next cycle.
- dealloc_i clears valid, mask and probes_set of dealloc_idx_i at the next edge. Dealloc of a non-live entry has no effect.
- set_probes_i on a live entry loads mask = probes_mask_i and sets probes_set. On a non-live entry it is ignored.
- probe_ack_i on a live entry clears bit probe_ack_core_i of that entry's mask. Ack of an already-clear bit or a non-live entry is ignored.
- set_probes and probe_ack to the same entry in the same cycle: new mask = probes_mask_i & ~onehot(probe_ack_core_i).
- Any ordering against dealloc on the same entry: dealloc wins.
- Alloc and set_probes/probe_ack to different entries in the same cycle are all applied.
- probes_done_o[i] = valid & probes_set & (mask == 0). A zero probes_mask_i therefore signals done one cycle after set_probes_i.
- count_o tracks live entries. Alloc and dealloc in the same cycle leave count_o unchanged. count_o never exceeds ENTRIES or wraps below 0.
- Reset mid-operation drops all entries immediately, with no partial state retained.

Test Plan:
- After reset, alloc addr 0x1000 src 5 type 4 -> alloc_idx_o=0. Next cycle valid_o=4'b0001, entry 0 addr 0x1000, count_o=1.
- Alloc 0x1000, then 0x1020 (same 64 B line) -> alloc_conflict_o=1, alloc_ready_o=0. Alloc 0x1040 -> accepted into idx 1.
- Fill 4 entries -> full_o=1, alloc_ready_o=0. Dealloc idx 2 while alloc_valid_i held -> not accepted that cycle; accepted next cycle with alloc_idx_o=2.
- Entry 1: set_probes mask 4'b1011 -> pending 1011, probes_done_o[1]=0. Ack cores 0, 3, 1 on successive cycles -> pending 1010, 0010, 0000; probes_done_o[1]=1 after the third ack.
- Same cycle: set_probes idx 0 mask 4'b1111 plus ack idx 0 core 2 -> pending 1011. Ack to non-live idx 3 -> no change.
- rst_n low while 3 entries live with pending probes -> all outputs 0 immediately. After release, first alloc gets idx 0.
